// File: rtl/dcache_ctrl_if.sv
// Interfaces for dcache_ctrl.
//   dcache_req_if : memory-stage MMIO request channel (master = memory stage,
//                   slave = cache controller).
//   dcache_bus_if : external single-word memory bus (master = cache
//                   controller, slave = memory / bus fabric).

interface dcache_req_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_pulse;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_write;
    logic [DATA_W-1:0] data_read;
    logic              dack;

    modport master (
        output req_pulse, rw, addr, data_write,
        input  data_read, dack
    );

    modport slave (
        input  req_pulse, rw, addr, data_write,
        output data_read, dack
    );
endinterface

interface dcache_bus_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate data cache
// with a single-word external bus controller.
//   - Read hits complete combinationally in the request cycle.
//   - Read misses and all writes run one bus transaction; dack is raised in
//     the cycle the bus acknowledges.
// Optional feature macro: DCACHE_UNCACHED_EN
//   When defined, addresses with addr[31:28] == 4'hF bypass the cache:
//   reads never hit and never fill, writes never update a line.

module dcache_ctrl #(
    parameter int INDEX_BITS = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    dcache_req_if.slave  req,
    dcache_bus_if.master bus
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

`ifdef DCACHE_UNCACHED_EN
    localparam bit UNCACHED_EN = 1'b1;
`else
    localparam bit UNCACHED_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2
    } state_t;

    // Top nibble 4'hF is the MMIO window when the uncached feature is built in.
    function automatic logic is_uncached(input logic [ADDR_W-1:0] a);
        return UNCACHED_EN && (a[ADDR_W-1 -: 4] == 4'hF);
    endfunction

    state_t              state_q, state_d;
    logic                bus_req_q, bus_req_d;
    logic                bus_we_q, bus_we_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic [LINES-1:0]    valid_q, valid_d;

    // Tag and data storage carry no reset; valid_q alone qualifies them.
    logic [TAG_W-1:0]    tag_arr  [LINES];
    logic [DATA_W-1:0]   data_arr [LINES];

    logic [INDEX_BITS-1:0] req_idx, lat_idx;
    logic [TAG_W-1:0]      req_tag, lat_tag;
    logic                  hit_live;
    logic                  lat_hit;
    logic                  fill_en;
    logic                  upd_en;
    logic                  dack_c;
    logic [DATA_W-1:0]     data_read_c;

    // Byte-offset bits carry no information for a word cache.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^req.addr[1:0];

    // Live request lookup uses the memory stage's address; completion-time
    // lookup uses the address latched into the bus register.
    assign req_idx = req.addr[INDEX_BITS+1:2];
    assign req_tag = req.addr[ADDR_W-1:INDEX_BITS+2];
    assign lat_idx = bus_addr_q[INDEX_BITS+1:2];
    assign lat_tag = bus_addr_q[ADDR_W-1:INDEX_BITS+2];

    assign hit_live = valid_q[req_idx] && (tag_arr[req_idx] == req_tag)
                      && !is_uncached(req.addr);
    assign lat_hit  = valid_q[lat_idx] && (tag_arr[lat_idx] == lat_tag)
                      && !is_uncached(bus_addr_q);

    // Next-state, bus register and completion decode.
    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        valid_d     = valid_q;
        fill_en     = 1'b0;
        upd_en      = 1'b0;
        dack_c      = 1'b0;
        data_read_c = '0;

        unique case (state_q)
            IDLE: begin
                if (req.req_pulse) begin
                    if (req.rw) begin
                        if (hit_live) begin
                            dack_c      = 1'b1;
                            data_read_c = data_arr[req_idx];
                        end else begin
                            bus_req_d  = 1'b1;
                            bus_we_d   = 1'b0;
                            bus_addr_d = {req.addr[ADDR_W-1:2], 2'b00};
                            state_d    = RD_MISS;
                        end
                    end else begin
                        bus_req_d   = 1'b1;
                        bus_we_d    = 1'b1;
                        bus_addr_d  = {req.addr[ADDR_W-1:2], 2'b00};
                        bus_wdata_d = req.data_write;
                        state_d     = WR_THRU;
                    end
                end
            end

            RD_MISS: begin
                if (bus.bus_ack) begin
                    dack_c      = 1'b1;
                    data_read_c = bus.bus_rdata;
                    fill_en     = !is_uncached(bus_addr_q);
                    bus_req_d   = 1'b0;
                    state_d     = IDLE;
                end
            end

            WR_THRU: begin
                if (bus.bus_ack) begin
                    dack_c    = 1'b1;
                    upd_en    = lat_hit;
                    bus_req_d = 1'b0;
                    bus_we_d  = 1'b0;
                    state_d   = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (fill_en) begin
            valid_d[lat_idx] = 1'b1;
        end

        // Nothing completes while reset is held; any array write is squashed too.
        if (rst) begin
            dack_c      = 1'b0;
            data_read_c = '0;
            fill_en     = 1'b0;
            upd_en      = 1'b0;
        end
    end

    // Control and bus registers; reset abandons any outstanding transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            valid_q     <= valid_d;
        end
    end

    // Line storage: read-miss fill writes tag and data, write-through hit
    // refreshes data only.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_arr[lat_idx]  <= lat_tag;
            data_arr[lat_idx] <= bus.bus_rdata;
        end else if (upd_en) begin
            data_arr[lat_idx] <= bus_wdata_q;
        end
    end

    assign req.dack      = dack_c;
    assign req.data_read = data_read_c;

    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate data cache and bus controller.
- Serves the memory stage's MMIO request interface (req_pulse/rw/addr/data_write → data_read/dack).
- Read hits acknowledge combinationally in the request cycle. Read misses and all writes run a single-word transaction on the external memory bus, and dack is raised in the cycle the bus acknowledges.
- Sits directly downstream of the memory stage, between it and the system memory bus.

Parameters:
- INDEX_BITS, 4, log2 of line count (16 one-word lines).
- ADDR_W, 32, address width.
- DATA_W, 32, data and line width (one word per line).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- req_pulse  input  1  request strobe from memory stage, sampled only in IDLE
- rw  input  1  1 = read, 0 = write
- addr  input  32  byte address; bits [1:0] ignored
- data_write  input  32  store data
- data_read  output  32  load data; valid when dack=1 and the request was a read
- dack  output  1  one-cycle completion strobe (combinational)
- bus_req  output  1  registered bus request, level-held until bus_ack
- bus_we  output  1  registered; 1 = bus write
- bus_addr  output  32  registered word-aligned address ({addr[31:2],2'b00})
- bus_wdata  output  32  registered write data
- bus_rdata  input  32  bus read data, valid with bus_ack
- bus_ack  input  1  bus completion strobe, one cycle

Behaviour:
- Address split:
  - index = addr[INDEX_BITS+1:2]
  - tag = addr[31:INDEX_BITS+2]
  - per line: valid bit, tag, data word.
- hit = valid[index] && tag match, evaluated combinationally on the live addr.
- States: IDLE, RD_MISS, WR_THRU.
- IDLE:
  - req_pulse && rw && hit: dack=1 and data_read=line data in the same cycle; stay in IDLE.
  - req_pulse && rw && !hit: latch addr, set bus_req=1 and bus_we=0 next cycle; go to RD_MISS.
  - req_pulse && !rw: latch addr/data, set bus_req=1 and bus_we=1 next cycle; go to WR_THRU. No dack in the request cycle.
- RD_MISS:
  - Hold bus_req and the bus fields stable until bus_ack.
  - On bus_ack: dack=1, data_read=bus_rdata (combinational pass-through); fill the line (valid=1, tag, data) at the clock edge; drop bus_req; go to IDLE.
- WR_THRU:
  - On bus_ack: dack=1; if the latched address hits, update the line data (valid and tag unchanged); a miss leaves the cache untouched (no allocate); drop bus_req; go to IDLE.
- Latency:
  - Read hit: 0 cycles.
  - Miss or write: 1 cycle to bus_req plus bus latency. The earliest legal bus_ack is the first cycle bus_req=1, giving dack 1 cycle after req_pulse.
- req_pulse in RD_MISS or WR_THRU is ignored. The memory stage holds rw/addr/data stable while stalled.
- bus_ack while bus_req=0 is ignored.
- data_read = 0 whenever dack=0, and on write acks.
- A conflicting read miss overwrites the resident line unconditionally; there is no dirty state.
- Reset (any state, including mid-transaction):
  - State returns to IDLE.
  - All valid bits clear.
  - bus_req, bus_we = 0; bus_addr, bus_wdata = 0.
  - dack, data_read = 0.
  - The outstanding bus transaction is abandoned; a late bus_ack after reset is ignored.
  - Tag and data arrays need not be reset.

Optional Feature:
- Macro: DCACHE_UNCACHED_EN.
- When defined, addresses with addr[31:28]==4'hF are MMIO-uncached:
  - Reads always miss: they take the RD_MISS path but do not fill the line.
  - Writes take WR_THRU but never update a line, even on a tag match.
- When undefined, all addresses are cacheable as described above.

Test Plan:
- Cold read 0x0000_0040, bus returns 0xDEADBEEF after 3 cycles → bus_req 1 cycle after req_pulse with bus_we=0 and bus_addr=0x40; dack and data_read=0xDEADBEEF in the bus_ack cycle; bus_req=0 in the next cycle.
- Repeat read 0x0000_0040 → dack=1 and data_read=0xDEADBEEF in the req_pulse cycle; bus_req stays 0.
- Write 0x12345678 to 0x0000_0040 (hit), bus_ack after 2 cycles → bus_we=1, bus_wdata=0x12345678; dack on ack; a following read hits with 0x12345678.
- Write to 0x0000_0080 (miss), then read 0x0000_0080 → write creates no line; the read goes to the bus (miss). Then read 0x0000_0440 (same index as 0x40, different tag) → miss and eviction; a subsequent read of 0x40 misses.
- Assert rst while in RD_MISS with bus_req=1, then pulse bus_ack the cycle after reset deasserts → bus_req=0, no dack; a read of 0x40 misses (valid cleared).
- With DCACHE_UNCACHED_EN: read 0xF000_0000 twice, bus returns 0x55 then 0x66 → both reads go to the bus, dack data is 0x55 then 0x66, no fill.
